// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 8:1 TDM link (mux and demux ends).
package tdm_pkg;

    localparam int N_SLOTS = 8;
    localparam int SLOT_W  = $clog2(N_SLOTS);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: load-to-1 on frame start, increment per bit, clear on completion.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int SLOT_W_P = SLOT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_one,
    input  logic                inc,
    input  logic                clr,
    output logic [SLOT_W_P-1:0] count
);

    logic [SLOT_W_P-1:0] count_q;
    logic [SLOT_W_P-1:0] count_d;

    // Next count: clear wins, then a new frame start, then a bit advance, else hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load_one) begin
            count_d = SLOT_W_P'(1);
        end else if (inc) begin
            count_d = count_q + SLOT_W_P'(1);
        end
    end

    // Counter register with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux8.sv
// 1-to-8 TDM demultiplexer: reassembles slot bits into a word, flags early restarts.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int N_SLOTS_P = N_SLOTS,
    parameter int SLOT_W_P  = SLOT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [N_SLOTS_P-1:0] out,
    output logic                 frame_valid,
    output logic [SLOT_W_P-1:0]  slot,
    output logic                 busy,
    output logic                 frame_err
);

    localparam logic [SLOT_W_P-1:0] LAST_SLOT = SLOT_W_P'(N_SLOTS_P - 1);

    tdm_state_t           state_q, state_d;
    logic [N_SLOTS_P-1:0] shadow_q, shadow_d;
    logic [N_SLOTS_P-1:0] out_q, out_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ctr_load, ctr_inc, ctr_clr;
    logic [SLOT_W_P-1:0]  slot_cnt;
    logic                 acc;
    logic                 data_bit;

    assign acc      = din_valid & sof;
    assign data_bit = din_valid & ~sof;

    tdm_slot_ctr #(
        .SLOT_W_P (SLOT_W_P)
    ) u_slot_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_one (ctr_load),
        .inc      (ctr_inc),
        .clr      (ctr_clr),
        .count    (slot_cnt)
    );

    // Frame FSM next-state: steer bits into the shadow, publish on the last slot.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        ctr_load      = 1'b0;
        ctr_inc       = 1'b0;
        ctr_clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    shadow_d[0] = din;
                    ctr_load    = 1'b1;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (acc) begin
                    frame_err_d = 1'b1;
                    shadow_d[0] = din;
                    ctr_load    = 1'b1;
                end else if (data_bit) begin
                    if (slot_cnt == LAST_SLOT) begin
                        out_d                = shadow_q;
                        out_d[N_SLOTS_P-1]   = din;
                        frame_valid_d        = 1'b1;
                        ctr_clr              = 1'b1;
                        state_d              = IDLE;
                    end else begin
                        shadow_d[slot_cnt] = din;
                        ctr_inc            = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and registered outputs, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            out_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign out         = out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign slot        = slot_cnt;
    assign busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8: driver feeds a frame-level model, monitor checks strobes.
module tb_tdm_demux8;
    import tdm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [7:0] out;
    logic       frame_valid;
    logic [2:0] slot;
    logic       busy;
    logic       frame_err;

    tdm_demux8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .out         (out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t  exp_q[$];
    bit   model_bits[$];
    bit   in_frame;
    int   exp_slot;
    logic [7:0] mon_out;
    int   n_checks;
    int   n_fail;
    int   n_frames;
    int   n_errs;

    // Compare one observed value with its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame-level reference: collect bits into a list, emit a word or an abort.
    task automatic modelStep(input bit d, input bit v, input bit s);
        logic [7:0] w;
        ev_t e;
        if (v && s) begin
            if (in_frame) begin
                e.is_err = 1'b1;
                e.data   = 8'h00;
                exp_q.push_back(e);
            end
            model_bits.delete();
            model_bits.push_back(d);
            in_frame = 1'b1;
        end else if (v && in_frame) begin
            model_bits.push_back(d);
            if (model_bits.size() == 8) begin
                w = 8'h00;
                for (int k = 0; k < 8; k++) w[k] = model_bits[k];
                e.is_err = 1'b0;
                e.data   = w;
                exp_q.push_back(e);
                model_bits.delete();
                in_frame = 1'b0;
            end
        end
        exp_slot = in_frame ? model_bits.size() : 0;
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model at the rising edge.
    task automatic applyStimulus(input bit d, input bit v, input bit s);
        @(negedge clk);
        din       = d;
        din_valid = v;
        sof       = s;
        @(posedge clk);
        if (rst_n) modelStep(d, v, s);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom), 1'b0, 1'($urandom));
    endtask

    // Send a word slot 0 first, optionally with a stall gap after chosen slots.
    task automatic sendFrame(input logic [7:0] w, input logic [7:0] stall_after, input int gap);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(w[k], 1'b1, k == 0);
            if (stall_after[k]) idleCycles(gap);
        end
    endtask

    task automatic assertReset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        model_bits.delete();
        exp_q.delete();
        in_frame = 1'b0;
        exp_slot = 0;
        for (int i = 0; i < n; i++) applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: sample after each rising edge and pop the scoreboard on strobes.
    initial begin
        bit exp_fv;
        bit exp_err;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                mon_out = 8'h00;
                checkOutput("rst_out", out, 0);
                checkOutput("rst_slot", slot, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_strobes", {frame_valid, frame_err}, 0);
            end else begin
                exp_fv  = (exp_q.size() > 0) && !exp_q[0].is_err;
                exp_err = (exp_q.size() > 0) && exp_q[0].is_err;
                if (exp_fv) mon_out = exp_q[0].data;
                if (exp_fv) n_frames++;
                if (exp_err) n_errs++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                checkOutput("frame_valid", frame_valid, exp_fv);
                checkOutput("frame_err", frame_err, exp_err);
                checkOutput("out", out, mon_out);
                checkOutput("slot", slot, exp_slot);
                checkOutput("busy", busy, exp_slot != 0);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        sof       = 1'b0;
        in_frame  = 1'b0;
        exp_slot  = 0;
        mon_out   = 8'h00;
        n_checks  = 0;
        n_fail    = 0;
        n_frames  = 0;
        n_errs    = 0;

        // Reset with random inputs, then the first frame.
        assertReset(4);
        sendFrame(8'hAA, 8'h00, 0);
        idleCycles(2);

        // Stalls after slot 2 and slot 5.
        sendFrame(8'hAA, 8'b0010_0100, 3);
        idleCycles(2);

        // Back-to-back frames with no bubble.
        sendFrame(8'hAA, 8'h00, 0);
        sendFrame(8'h0F, 8'h00, 0);
        idleCycles(2);

        // Early restart at slot 4, then a full frame.
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, k == 0);
        sendFrame(8'h3C, 8'h00, 0);
        idleCycles(2);

        // Restart exactly at the last slot.
        for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, k == 0);
        sendFrame(8'hC5, 8'h00, 0);
        idleCycles(1);

        // Orphan data and unqualified sof in IDLE.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);

        // Reset mid-frame at slot 6, then an all-ones frame.
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, k == 0);
        assertReset(2);
        sendFrame(8'hFF, 8'h00, 0);
        idleCycles(2);

        // Randomized traffic: frames, stalls, early restarts and orphans.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(11, 0) == 0));
        end
        for (int i = 0; i < 20; i++) begin
            sendFrame(8'($urandom), 8'($urandom) & 8'h7F, $urandom_range(2, 0));
        end
        idleCycles(3);

        $display("[TB] frames seen %0d, aborts seen %0d", n_frames, n_errs);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
